// File: rtl/spi_transaction_ctrl_if.sv
// Bus between the SPI transaction sequencer, the register file and the MISO shift datapath.
interface spi_transaction_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 7
);
  logic                  mosi;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  tx_load;
  logic [7:0]            word_count;
  logic                  is_read;

  // rd_data is consumed by the MISO datapath on tx_load, never by the sequencer itself.
  modport master (
    input  mosi,
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, tx_load, word_count, is_read
  );

  modport slave (
    output mosi, rd_data,
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, tx_load, word_count, is_read
  );
endinterface

// File: rtl/spi_transaction_ctrl.sv
// SPI slave command sequencer: header decode, per-word write/read-fetch strobes, burst addressing.
// Define SPI_CTRL_AUTO_INC_EN for burst address auto-increment; otherwise the address is fixed.
module spi_transaction_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 7
) (
  input logic                  valid_clk,
  input logic                  reset,
  spi_transaction_ctrl_if.master bus
);
  localparam int unsigned CmdW   = ADDR_WIDTH + 1;
  localparam int unsigned MaxLen = (CmdW > DATA_WIDTH) ? CmdW : DATA_WIDTH;
  localparam int unsigned CntW   = $clog2(MaxLen);

  typedef enum logic [1:0] {StCmd, StWrite, StRead} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [CmdW-2:0]       hdr_q, hdr_d;
  logic [DATA_WIDTH-2:0] rx_q, rx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_next;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]            word_count_q, word_count_d, word_count_inc;
  logic                  is_read_q, is_read_d;

  logic [CmdW-1:0]       hdr_full;
  logic [DATA_WIDTH-1:0] rx_full;
  logic                  hdr_done, word_done;

  assign hdr_full  = {hdr_q, bus.mosi};
  assign rx_full   = {rx_q, bus.mosi};
  assign hdr_done  = (bit_cnt_q == CntW'(CmdW - 1));
  assign word_done = (bit_cnt_q == CntW'(DATA_WIDTH - 1));

`ifdef SPI_CTRL_AUTO_INC_EN
  assign addr_next = addr_q + ADDR_WIDTH'(1);
`else
  assign addr_next = addr_q;
`endif

  assign word_count_inc = (word_count_q == 8'hFF) ? word_count_q : word_count_q + 8'd1;

  always_ff @(posedge valid_clk or posedge reset) begin
    if (reset) begin
      state_q <= StCmd;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCmd: begin
        if (hdr_done) begin
          state_d = hdr_full[CmdW-1] ? StRead : StWrite;
        end
      end
      StWrite: state_d = StWrite;
      StRead:  state_d = StRead;
      default: state_d = StCmd;
    endcase
  end

  always_comb begin
    bit_cnt_d    = bit_cnt_q + CntW'(1);
    hdr_d        = hdr_q;
    rx_d         = rx_q;
    addr_d       = addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    word_count_d = word_count_q;
    is_read_d    = is_read_q;
    unique case (state_q)
      StCmd: begin
        hdr_d = hdr_full[CmdW-2:0];
        if (hdr_done) begin
          bit_cnt_d = '0;
          addr_d    = hdr_full[ADDR_WIDTH-1:0];
          is_read_d = hdr_full[CmdW-1];
          // Reads prefetch the first word straight off the header.
          if (hdr_full[CmdW-1]) begin
            rd_en_d   = 1'b1;
            rd_addr_d = hdr_full[ADDR_WIDTH-1:0];
          end
        end
      end
      StWrite: begin
        rx_d = rx_full[DATA_WIDTH-2:0];
        if (word_done) begin
          bit_cnt_d    = '0;
          wr_en_d      = 1'b1;
          wr_addr_d    = addr_q;
          wr_data_d    = rx_full;
          addr_d       = addr_next;
          word_count_d = word_count_inc;
        end
      end
      StRead: begin
        if (word_done) begin
          bit_cnt_d    = '0;
          rd_en_d      = 1'b1;
          rd_addr_d    = addr_next;
          addr_d       = addr_next;
          word_count_d = word_count_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge valid_clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q    <= '0;
      hdr_q        <= '0;
      rx_q         <= '0;
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      word_count_q <= '0;
      is_read_q    <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      hdr_q        <= hdr_d;
      rx_q         <= rx_d;
      addr_q       <= addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      word_count_q <= word_count_d;
      is_read_q    <= is_read_d;
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.rd_en      = rd_en_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.tx_load    = rd_en_q;
  assign bus.word_count = word_count_q;
  assign bus.is_read    = is_read_q;
endmodule

// File: tb/tb_spi_transaction_ctrl.sv
// Randomized bench for spi_transaction_ctrl; expected strobes are derived from edge arithmetic.
module tb_spi_transaction_ctrl;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 7;
  localparam int unsigned CW = AW + 1;

  logic valid_clk = 1'b0;
  logic reset     = 1'b1;

  spi_transaction_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  spi_transaction_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .valid_clk (valid_clk),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 valid_clk = ~valid_clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [DW-1:0] word_mem [0:299];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, " wr_en"}, 32'(bus.wr_en), 32'd0);
    check_val({tag, " rd_en"}, 32'(bus.rd_en), 32'd0);
    check_val({tag, " tx_load"}, 32'(bus.tx_load), 32'd0);
    check_val({tag, " word_count"}, 32'(bus.word_count), 32'd0);
    check_val({tag, " is_read"}, 32'(bus.is_read), 32'd0);
    check_val({tag, " wr_addr"}, 32'(bus.wr_addr), 32'd0);
    check_val({tag, " wr_data"}, 32'(bus.wr_data), 32'd0);
    check_val({tag, " rd_addr"}, 32'(bus.rd_addr), 32'd0);
  endtask

  function automatic int unsigned word_addr(input int unsigned start, input int unsigned idx);
`ifdef SPI_CTRL_AUTO_INC_EN
    return (start + idx) % (1 << AW);
`else
    return start;
`endif
  endfunction

  // Runs one CS-low window of total_bits edges, then raises reset right after the last edge.
  task automatic run_txn(input bit rd, input int unsigned start, input int unsigned total_bits);
    logic [CW-1:0] hdr;
    logic [DW-1:0] w;
    hdr = {rd, AW'(start)};
    @(negedge valid_clk);
    for (int unsigned k = 1; k <= total_bits; k++) begin
      if (k <= CW) begin
        bus.mosi = hdr[CW-k];
      end else if (rd) begin
        bus.mosi = 1'($urandom);
      end else begin
        w = word_mem[(k - CW - 1) / DW];
        bus.mosi = w[DW - 1 - ((k - CW - 1) % DW)];
      end
      bus.rd_data = DW'($urandom);
      reset = 1'b0;
      @(posedge valid_clk);
      #1;
      begin
        bit          strobe;
        int unsigned n;
        int unsigned wc;
        strobe = (k >= CW) && ((k - CW) % DW == 0);
        n      = (k >= CW) ? (k - CW) / DW : 0;
        wc     = (n > 255) ? 255 : n;
        check_val("word_count", 32'(bus.word_count), wc);
        check_val("is_read", 32'(bus.is_read), (k >= CW) ? 32'(rd) : 32'd0);
        check_val("tx_load", 32'(bus.tx_load), 32'(rd && strobe));
        check_val("rd_en", 32'(bus.rd_en), 32'(rd && strobe));
        check_val("wr_en", 32'(bus.wr_en), 32'(!rd && strobe && n >= 1));
        if (rd && strobe) begin
          check_val("rd_addr", 32'(bus.rd_addr), word_addr(start, n));
        end
        if (!rd && strobe && n >= 1) begin
          check_val("wr_addr", 32'(bus.wr_addr), word_addr(start, n - 1));
          check_val("wr_data", 32'(bus.wr_data), 32'(word_mem[n - 1]));
        end
      end
      if (k != total_bits) @(negedge valid_clk);
    end
    // No further edge: outputs must fall from reset alone.
    reset = 1'b1;
    #1;
    check_idle("after reset");
  endtask

  initial begin
    bus.mosi    = 1'b0;
    bus.rd_data = '0;
    for (int i = 0; i < 300; i++) word_mem[i] = DW'($urandom);
    #12;
    check_idle("reset state");

    word_mem[0] = 16'hA5C3;
    run_txn(1'b0, 32'h05, CW + DW);
    word_mem[0] = 16'h1111;
    word_mem[1] = 16'h2222;
    run_txn(1'b0, 32'h7F, CW + 2 * DW);
    run_txn(1'b1, 32'h03, CW + 2 * DW + 5);
    run_txn(1'b0, 32'h22, CW + 11);
    run_txn(1'b0, 32'h10, 5);
    run_txn(1'b1, 32'h7E, CW + 3 * DW);
    for (int i = 0; i < 300; i++) word_mem[i] = DW'($urandom);
    run_txn(1'b0, 32'h33, CW + 260 * DW);
    run_txn(1'b1, 32'h41, CW + 260 * DW);

    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 8; i++) word_mem[i] = DW'($urandom);
      run_txn(1'($urandom), $urandom_range(0, (1 << AW) - 1),
              $urandom_range(1, CW + 5 * DW - 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
